// File: rtl/adc_pll_pkg.sv
// Shared constants for the ADC sampling-PLL reset/lock sequencer.
package adc_pll_pkg;

  typedef logic [2:0] state_t;

  localparam state_t RESET_PLL = 3'd0;
  localparam state_t WAIT_LOCK = 3'd1;
  localparam state_t STABLE    = 3'd2;
  localparam state_t RUN       = 3'd3;
  localparam state_t FAULT     = 3'd4;

  localparam int unsigned DEF_PLL_RST_CYCLES      = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int unsigned DEF_MAX_ATTEMPTS        = 4;
  localparam int unsigned DEF_CNT_W               = 16;

  localparam int unsigned LLC_W = 8;
  localparam int unsigned ATT_W = 4;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with async active-low reset (resets to 0).
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/adc_pll_reset_seq.sv
// PLL reset/lock sequencer: pulses PLL reset, qualifies lock, releases sys reset,
// recovers from lock loss and latches a fault after repeated failed attempts.
//
// state     | meaning
// RESET_PLL | pll_rst held high for PLL_RST_CYCLES
// WAIT_LOCK | waiting for synchronized lock, bounded by LOCK_TIMEOUT_CYCLES
// STABLE    | lock must hold LOCK_STABLE_CYCLES uninterrupted
// RUN       | downstream released, ready high
// FAULT     | too many failed attempts; waits for relock_req
module adc_pll_reset_seq
  import adc_pll_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned MAX_ATTEMPTS        = DEF_MAX_ATTEMPTS,
  parameter int unsigned CNT_W               = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             pll_locked_i,
  input  logic             relock_req_i,
  output logic             pll_rst_o,
  output logic             sys_rst_n_o,
  output logic             ready_o,
  output logic             fault_o,
  output logic [LLC_W-1:0] lock_loss_cnt_o,
  output logic [ATT_W-1:0] attempt_cnt_o
);

  localparam logic [CNT_W-1:0] RST_TC = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_TC = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_TC  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MAX_ATTEMPTS);

  logic             lk;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ATT_W-1:0] att_q, att_d;
  logic [LLC_W-1:0] llc_q, llc_d;
  logic             pll_rst_q, sys_rst_n_q, ready_q, fault_q;

  sync_2ff u_lock_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (pll_locked_i),
    .q_o     (lk)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    att_d   = att_q;
    llc_d   = llc_q;
    case (state_q)
      RESET_PLL: begin
        if (relock_req_i) begin
          cnt_d = '0;
        end else if (cnt_q == RST_TC) begin
          state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        // relock outranks a coincident timeout so no attempt is charged
        if (relock_req_i) begin
          state_d = RESET_PLL;
        end else if (lk) begin
          state_d = STABLE;
        end else if (cnt_q == TO_TC) begin
          att_d   = att_q + ATT_W'(1);
          state_d = (att_d == ATT_MAX) ? FAULT : RESET_PLL;
        end
      end
      STABLE: begin
        if (relock_req_i) begin
          state_d = RESET_PLL;
        end else if (!lk) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STB_TC) begin
          state_d = RUN;
          att_d   = '0;
        end
      end
      RUN: begin
        // lock loss outranks relock so it is always counted
        if (!lk) begin
          state_d = RESET_PLL;
          if (llc_q != '1) llc_d = llc_q + LLC_W'(1);
        end else if (relock_req_i) begin
          state_d = RESET_PLL;
        end
      end
      FAULT: begin
        if (relock_req_i) begin
          state_d = RESET_PLL;
          att_d   = '0;
        end
      end
      default: begin
        state_d = RESET_PLL;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      att_q       <= '0;
      llc_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      att_q       <= att_d;
      llc_q       <= llc_d;
      pll_rst_q   <= (state_d == RESET_PLL);
      sys_rst_n_q <= (state_d == RUN);
      ready_q     <= (state_d == RUN);
      fault_q     <= (state_d == FAULT);
    end
  end

  assign pll_rst_o       = pll_rst_q;
  assign sys_rst_n_o     = sys_rst_n_q;
  assign ready_o         = ready_q;
  assign fault_o         = fault_q;
  assign lock_loss_cnt_o = llc_q;
  assign attempt_cnt_o   = att_q;

endmodule

// File: tb/tb_adc_pll_reset_seq.sv
// Scoreboard bench: stimulus queues hand-computed output changes (edge index + values),
// a negedge monitor pops one entry for every change it observes on the outputs.
module tb_adc_pll_reset_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fault;
  logic [7:0] llc;
  logic [3:0] att;

  always #5 clk = ~clk;

  adc_pll_reset_seq #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (20),
    .MAX_ATTEMPTS        (3),
    .CNT_W               (16)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .pll_locked_i    (pll_locked),
    .relock_req_i    (relock_req),
    .pll_rst_o       (pll_rst),
    .sys_rst_n_o     (sys_rst_n),
    .ready_o         (ready),
    .fault_o         (fault),
    .lock_loss_cnt_o (llc),
    .attempt_cnt_o   (att)
  );

  typedef struct {
    int          cyc;
    logic [15:0] v;
  } exp_t;

  exp_t  q[$];
  exp_t  me;
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;
  logic [15:0] cur, prev;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pk(logic pr, logic sr, logic rd, logic ft, int a, int l);
    return {pr, sr, rd, ft, a[3:0], l[7:0]};
  endfunction

  task automatic push(int c, logic pr, logic sr, logic rd, logic ft, int a, int l);
    exp_t e;
    e.cyc = c;
    e.v   = pk(pr, sr, rd, ft, a, l);
    q.push_back(e);
  endtask

  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge clk);
  endtask

  // fields: pll_rst sys_rst_n ready fault attempt_cnt lock_loss_cnt
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {pll_rst, sys_rst_n, ready, fault, att, llc};
      if (cur !== prev) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change at edge %0d: got pr=%b sr=%b rdy=%b flt=%b att=%0d llc=%0d, none required",
                   cyc, cur[15], cur[14], cur[13], cur[12], cur[11:8], cur[7:0]);
        end else begin
          me = q.pop_front();
          if (me.cyc != cyc || me.v !== cur) begin
            n_fail++;
            $display("FAIL output_event: got edge %0d pr=%b sr=%b rdy=%b flt=%b att=%0d llc=%0d, required edge %0d pr=%b sr=%b rdy=%b flt=%b att=%0d llc=%0d",
                     cyc, cur[15], cur[14], cur[13], cur[12], cur[11:8], cur[7:0],
                     me.cyc, me.v[15], me.v[14], me.v[13], me.v[12], me.v[11:8], me.v[7:0]);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r, a0, f, w, l, el;

    repeat (3) @(negedge clk);
    n_tests++;
    if ({pll_rst, sys_rst_n, ready, fault, att, llc} !== pk(1, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_state: got pr=%b sr=%b rdy=%b flt=%b att=%0d llc=%0d, required pr=1 sr=0 rdy=0 flt=0 att=0 llc=0",
               pll_rst, sys_rst_n, ready, fault, att, llc);
    end
    prev   = {pll_rst, sys_rst_n, ready, fault, att, llc};
    mon_en = 1'b1;

    // nominal bring-up: lock 5 cycles after pll_rst falls
    r = cyc;
    push(r + 4, 0, 0, 0, 0, 0, 0);
    push(r + 20, 0, 1, 1, 0, 0, 0);
    rst_n = 1'b1;
    wait_cyc(r + 9);
    pll_locked = 1'b1;
    wait_cyc(r + 24);

    // unstable lock: 5 high, 1 low, then steady
    n = cyc;
    a0 = n + 7;
    push(n + 1, 1, 0, 0, 0, 0, 0);
    push(n + 5, 0, 0, 0, 0, 0, 0);
    push(a0 + 16, 0, 1, 1, 0, 0, 0);
    relock_req = 1'b1;
    pll_locked = 1'b0;
    @(negedge clk);
    relock_req = 1'b0;
    wait_cyc(n + 6);
    pll_locked = 1'b1;
    wait_cyc(a0 + 4);
    pll_locked = 1'b0;
    wait_cyc(a0 + 5);
    pll_locked = 1'b1;
    wait_cyc(a0 + 20);

    // timeouts into fault, then recovery via relock_req
    n = cyc;
    push(n + 1, 1, 0, 0, 0, 0, 0);
    push(n + 5, 0, 0, 0, 0, 0, 0);
    w = n + 5;
    for (int a = 1; a <= 2; a++) begin
      push(w + 20, 1, 0, 0, 0, a, 0);
      w = w + 24;
      push(w, 0, 0, 0, 0, a, 0);
    end
    push(w + 20, 0, 0, 0, 1, 3, 0);
    relock_req = 1'b1;
    pll_locked = 1'b0;
    @(negedge clk);
    relock_req = 1'b0;
    wait_cyc(n + 75);
    pll_locked = 1'b1;
    wait_cyc(n + 90);
    n_tests++;
    if (fault !== 1'b1 || pll_rst !== 1'b0 || sys_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_hold: got flt=%b pr=%b sr=%b, required flt=1 pr=0 sr=0", fault, pll_rst, sys_rst_n);
    end
    f = cyc;
    push(f + 1, 1, 0, 0, 0, 0, 0);
    push(f + 5, 0, 0, 0, 0, 0, 0);
    push(f + 14, 0, 1, 1, 0, 0, 0);
    relock_req = 1'b1;
    @(negedge clk);
    relock_req = 1'b0;
    wait_cyc(f + 16);

    // lock loss and relock_req seen in the same cycle
    n = cyc;
    push(n + 3, 1, 0, 0, 0, 0, 1);
    push(n + 7, 0, 0, 0, 0, 0, 1);
    push(n + 16, 0, 1, 1, 0, 0, 1);
    pll_locked = 1'b0;
    wait_cyc(n + 2);
    relock_req = 1'b1;
    @(negedge clk);
    relock_req = 1'b0;
    pll_locked = 1'b1;
    wait_cyc(n + 17);
    el = 1;

    // repeated lock loss in RUN; counter saturates
    for (int i = 0; i < 300; i++) begin
      n = cyc;
      l = (el < 255) ? el + 1 : 255;
      el = l;
      push(n + 3, 1, 0, 0, 0, 0, l);
      push(n + 7, 0, 0, 0, 0, 0, l);
      push(n + 16, 0, 1, 1, 0, 0, l);
      pll_locked = 1'b0;
      wait_cyc(n + 3);
      pll_locked = 1'b1;
      wait_cyc(n + 17);
    end
    n_tests++;
    if (llc !== 8'd255) begin
      n_fail++;
      $display("FAIL llc_saturate: got %0d, required 255", llc);
    end

    // async reset between edges while in STABLE
    n = cyc;
    push(n + 1, 1, 0, 0, 0, 0, 255);
    push(n + 5, 0, 0, 0, 0, 0, 255);
    relock_req = 1'b1;
    @(negedge clk);
    relock_req = 1'b0;
    wait_cyc(n + 9);
    #2;
    rst_n = 1'b0;
    push(n + 10, 1, 0, 0, 0, 0, 0);
    #1;
    n_tests++;
    if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || llc !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: got pr=%b sr=%b llc=%0d, required pr=1 sr=0 llc=0", pll_rst, sys_rst_n, llc);
    end
    wait_cyc(n + 12);
    r = cyc;
    push(r + 4, 0, 0, 0, 0, 0, 0);
    push(r + 13, 0, 1, 1, 0, 0, 0);
    rst_n = 1'b1;
    wait_cyc(r + 16);

    repeat (5) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: got %0d expected changes never seen, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
